// File: rtl/apb_reg_bridge_pkg.sv
// Shared types and address decode for the APB-to-register-file bridge.
package apb_reg_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Flags misaligned, out-of-window, unmapped, and read-only-write accesses.
   function automatic logic decode_err(input logic [31:0] addr,
                                       input logic        wr,
                                       input int          p_addr_w,
                                       input int          num_regs,
                                       input logic [63:0] ro_mask);
      logic [31:0] word;
      logic        bad;
      word = addr >> 2;
      bad  = (addr[1:0] != 2'b00)
          || ((addr >> (p_addr_w + 2)) != 32'd0)
          || (word >= 32'(num_regs));
      if (!bad && wr && (word < 32'd64) && ro_mask[word[5:0]])
         bad = 1'b1;
      return bad;
   endfunction

endpackage

// File: rtl/apb_reg_bridge.sv
// APB3 slave that forwards accesses over a req/ack handshake to the register bank,
// with address decode errors and a watchdog on hung peripheral requests.
module apb_reg_bridge
   import apb_reg_bridge_pkg::*;
#(
   parameter int          APB_DATA_W = 32,
   parameter int          P_ADDR_W   = 6,
   parameter int          P_DATA_W   = 16,
   parameter int          NUM_REGS   = 48,
   parameter logic [63:0] RO_MASK    = 64'h0,
   parameter int          TIMEOUT    = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic [31:0]           PADDR,
   input  logic                  PSELx,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [APB_DATA_W-1:0] PWDATA,
   output logic                  PREADY,
   output logic [APB_DATA_W-1:0] PRDATA,
   output logic                  PSLVERR,
   output logic [P_ADDR_W-1:0]   p_address,
   output logic [P_DATA_W-1:0]   p_data,
   output logic                  p_wr,
   output logic                  p_req,
   input  logic                  p_ack,
   input  logic [P_DATA_W-1:0]   p_data_back
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             timeout_hit;

   // The counter reads k-1 during the k-th BUSY cycle, so this fires on the last allowed cycle.
   assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state     <= ST_IDLE;
         PREADY    <= 1'b0;
         PSLVERR   <= 1'b0;
         PRDATA    <= '0;
         p_address <= '0;
         p_data    <= '0;
         p_wr      <= 1'b0;
         p_req     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (PSELx && !PENABLE) begin
                  p_address <= PADDR[P_ADDR_W+1:2];
                  p_data    <= PWDATA[P_DATA_W-1:0];
                  p_wr      <= PWRITE;
                  cnt       <= '0;
                  if (decode_err(PADDR, PWRITE, P_ADDR_W, NUM_REGS, RO_MASK)) begin
                     state   <= ST_RESP;
                     PREADY  <= 1'b1;
                     PSLVERR <= 1'b1;
                  end else begin
                     state <= ST_BUSY;
                     p_req <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               cnt <= cnt + 1'b1;
               if (p_ack) begin
                  if (!p_wr)
                     PRDATA <= APB_DATA_W'(p_data_back);
                  p_req   <= 1'b0;
                  PREADY  <= 1'b1;
                  PSLVERR <= 1'b0;
                  state   <= ST_RESP;
               end else if (timeout_hit) begin
                  p_req   <= 1'b0;
                  PREADY  <= 1'b1;
                  PSLVERR <= 1'b1;
                  state   <= ST_RESP;
               end
            end
            ST_RESP: begin
               PREADY  <= 1'b0;
               PSLVERR <= 1'b0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Randomized bench for apb_reg_bridge against a transaction-level reference model.
module tb_apb_reg_bridge;

   localparam int TMO = 16;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic [31:0] PADDR;
   logic        PSELx, PENABLE, PWRITE;
   logic [31:0] PWDATA;
   logic        PREADY, PSLVERR;
   logic [31:0] PRDATA;
   logic [5:0]  p_address;
   logic [15:0] p_data;
   logic        p_wr, p_req, p_ack;
   logic [15:0] p_data_back;

   int total = 0;
   int bad   = 0;
   logic [31:0] m_prdata;

   apb_reg_bridge #(
      .APB_DATA_W(32), .P_ADDR_W(6), .P_DATA_W(16), .NUM_REGS(48),
      .RO_MASK(64'h1), .TIMEOUT(TMO)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY),
      .PRDATA(PRDATA), .PSLVERR(PSLVERR), .p_address(p_address), .p_data(p_data),
      .p_wr(p_wr), .p_req(p_req), .p_ack(p_ack), .p_data_back(p_data_back)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   // ack_k: cycle after setup on which p_ack is raised; 0 means never.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input int ack_k, input logic [15:0] back);
      bit err, timed_out;
      int rdy_at;
      bit done;
      logic [31:0] a;
      a         = addr;
      err       = (addr % 4 != 0) || (addr / 4 >= 48) || (wr && addr / 4 == 0);
      timed_out = !err && (ack_k < 1 || ack_k > TMO);
      rdy_at    = err ? 1 : (timed_out ? TMO + 1 : ack_k + 1);

      PADDR = addr; PWRITE = wr; PWDATA = wdata; PSELx = 1'b1; PENABLE = 1'b0;
      p_ack = 1'b0; p_data_back = back;
      done = 0;
      for (int n = 1; n <= 40 && !done; n++) begin
         step();
         chk("p_req", p_req, (!err && n < rdy_at));
         chk("pready", PREADY, (n == rdy_at));
         if (n == rdy_at) begin
            done = 1;
            if (!err && !timed_out && !wr) m_prdata = {16'h0, back};
            chk("pslverr", PSLVERR, err || timed_out);
            chk("prdata", PRDATA, m_prdata);
            chk("p_address", p_address, a[7:2]);
            chk("p_wr", p_wr, wr);
            chk("p_data", p_data, wdata[15:0]);
         end
         PENABLE = 1'b1;
         p_ack   = (n == ack_k);
      end
      if (!done) chk("ready_bound", 0, 1);
      // idle cycle with a stray ack, which must have no effect
      step();
      PSELx = 1'b0; PENABLE = 1'b0; p_ack = 1'b1; p_data_back = 16'($urandom);
      step();
      p_ack = 1'b0;
      chk("idle_ready", PREADY, 0);
      chk("idle_req", p_req, 0);
      chk("idle_prdata", PRDATA, m_prdata);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, PREADY, 0);
      chk({tag, "_slverr"}, PSLVERR, 0);
      chk({tag, "_prdata"}, PRDATA, 0);
      chk({tag, "_addr"}, p_address, 0);
      chk({tag, "_data"}, p_data, 0);
      chk({tag, "_wr"}, p_wr, 0);
      chk({tag, "_req"}, p_req, 0);
   endtask

   initial begin
      PRESETn = 1'b0; PADDR = '0; PSELx = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0;
      p_ack = 0; p_data_back = '0; m_prdata = '0;
      step(); step();
      chk_zero("rst");
      PRESETn = 1'b1;
      step();

      xfer(32'h08, 1, 32'h0000_ABCD, 1, 16'h0);
      xfer(32'h0C, 0, 32'h0, 3, 16'h1234);
      xfer(32'hC0, 1, 32'h5555, 1, 16'h0);
      xfer(32'h05, 0, 32'h0, 1, 16'h0);
      xfer(32'h00, 1, 32'h7777, 1, 16'h0);
      xfer(32'h00, 0, 32'h0, 2, 16'hBEEF);
      xfer(32'h10, 0, 32'h0, 0, 16'h9999);
      xfer(32'h14, 0, 32'h0, TMO, 16'h4321);
      xfer(32'h18, 0, 32'h0, TMO + 1, 16'h1111);
      xfer(32'h1000_0004, 0, 32'h0, 1, 16'h2222);

      // reset in the middle of a hung write
      PADDR = 32'h20; PWRITE = 1; PWDATA = 32'h3C3C; PSELx = 1; PENABLE = 0;
      step();
      PENABLE = 1;
      step(); step();
      chk("pre_rst_req", p_req, 1);
      PRESETn = 1'b0;
      step();
      PRESETn = 1'b1; PSELx = 0; PENABLE = 0;
      m_prdata = '0;
      chk_zero("midrst");
      step();
      chk_zero("midrst_idle");
      xfer(32'h24, 1, 32'h0000_F00D, 2, 16'h0);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] addr;
         addr = 32'($urandom_range(0, 55)) * 4;
         case ($urandom_range(0, 9))
            0: addr = addr | 32'($urandom_range(1, 3));
            1: addr = addr | (32'h1 << $urandom_range(8, 31));
            default: ;
         endcase
         xfer(addr, 1'($urandom), $urandom, int'($urandom_range(0, 20)), 16'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
